// File: rtl/sliding_window_buffer_pkg.sv
// Shared convolution helpers.
// Holds the window flattening index and the derived-size formulas that the
// line buffer and the conv controllers both rely on.
package sliding_window_buffer_pkg;

    // Depth of the pixel shift array needed to expose a full k x k window.
    function automatic int fifo_size(input int ifm, input int k);
        return (k - 1) * ifm + k;
    endfunction

    // Edge length of the output map for a given window and stride.
    function automatic int ifm_size_next(input int ifm, input int k, input int s);
        return (ifm - k) / s + 1;
    endfunction

    // Flattened slot of window element (i, j); row-major, top-left first.
    function automatic int win_index(input int i, input int j, input int k);
        return i * k + j;
    endfunction

endpackage

// File: rtl/window_position_tracker.sv
// Raster position and window qualification for the sliding window buffer.
// Ports:
//   clk, reset (sync, active-low), clear (sync frame restart), in_valid
//   window_valid : registered, high the cycle after a pixel completes an
//                  aligned window
//   out_row/out_col : output-map coordinates of that window
//   frame_done   : high with the last window of the frame
module window_position_tracker
    import sliding_window_buffer_pkg::*;
#(
    parameter int IFM_SIZE      = 14,
    parameter int KERNAL_SIZE   = 5,
    parameter int STRIDE        = 1,
    parameter int IFM_SIZE_NEXT = ifm_size_next(IFM_SIZE, KERNAL_SIZE, STRIDE),
    parameter int COORD_BITS    = $clog2(IFM_SIZE)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  clear,
    input  logic                  in_valid,
    output logic                  window_valid,
    output logic [COORD_BITS-1:0] out_row,
    output logic [COORD_BITS-1:0] out_col,
    output logic                  frame_done
);

    localparam int PHASE_BITS = (STRIDE > 1) ? $clog2(STRIDE) : 1;

    localparam logic [COORD_BITS-1:0] InLast  = COORD_BITS'(IFM_SIZE - 1);
    localparam logic [COORD_BITS-1:0] KLast   = COORD_BITS'(KERNAL_SIZE - 1);
    localparam logic [COORD_BITS-1:0] OutLast = COORD_BITS'(IFM_SIZE_NEXT - 1);
    localparam logic [PHASE_BITS-1:0] PhLast  = PHASE_BITS'(STRIDE - 1);

    logic [COORD_BITS-1:0] in_row_q, in_row_d, in_col_q, in_col_d;
    logic [PHASE_BITS-1:0] row_ph_q, row_ph_d, col_ph_q, col_ph_d;
    // Coordinates the next qualifying window will carry.
    logic [COORD_BITS-1:0] win_row_q, win_row_d, win_col_q, win_col_d;
    logic [COORD_BITS-1:0] out_row_q, out_row_d, out_col_q, out_col_d;
    logic                  valid_q, valid_d, done_q, done_d;
    logic                  hit;

    always_comb begin
        in_row_d  = in_row_q;
        in_col_d  = in_col_q;
        row_ph_d  = row_ph_q;
        col_ph_d  = col_ph_q;
        win_row_d = win_row_q;
        win_col_d = win_col_q;
        out_row_d = out_row_q;
        out_col_d = out_col_q;
        valid_d   = 1'b0;
        done_d    = 1'b0;

        // Phases are zero exactly on stride-aligned rows/columns past the edge.
        hit = (in_row_q >= KLast) && (in_col_q >= KLast) &&
              (row_ph_q == '0) && (col_ph_q == '0);

        if (in_valid) begin
            if (in_col_q == InLast) begin
                in_col_d = '0;
                col_ph_d = '0;
                if (in_row_q == InLast) begin
                    in_row_d = '0;
                    row_ph_d = '0;
                end else begin
                    in_row_d = in_row_q + 1'b1;
                    if (in_row_q >= KLast) begin
                        row_ph_d = (row_ph_q == PhLast) ? '0 : row_ph_q + 1'b1;
                    end
                end
            end else begin
                in_col_d = in_col_q + 1'b1;
                if (in_col_q >= KLast) begin
                    col_ph_d = (col_ph_q == PhLast) ? '0 : col_ph_q + 1'b1;
                end
            end

            if (hit) begin
                valid_d   = 1'b1;
                out_row_d = win_row_q;
                out_col_d = win_col_q;
                done_d    = (win_row_q == OutLast) && (win_col_q == OutLast);
                if (win_col_q == OutLast) begin
                    win_col_d = '0;
                    win_row_d = (win_row_q == OutLast) ? '0 : win_row_q + 1'b1;
                end else begin
                    win_col_d = win_col_q + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset || clear) begin
            in_row_q  <= '0;
            in_col_q  <= '0;
            row_ph_q  <= '0;
            col_ph_q  <= '0;
            win_row_q <= '0;
            win_col_q <= '0;
            out_row_q <= '0;
            out_col_q <= '0;
            valid_q   <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            in_row_q  <= in_row_d;
            in_col_q  <= in_col_d;
            row_ph_q  <= row_ph_d;
            col_ph_q  <= col_ph_d;
            win_row_q <= win_row_d;
            win_col_q <= win_col_d;
            out_row_q <= out_row_d;
            out_col_q <= out_col_d;
            valid_q   <= valid_d;
            done_q    <= done_d;
        end
    end

    assign window_valid = valid_q;
    assign frame_done   = done_q;
    assign out_row      = out_row_q;
    assign out_col      = out_col_q;

endmodule

// File: rtl/sliding_window_buffer.sv
// Line buffer and window generator for the conv layers.
// Shifts a raster-order pixel stream through FIFO_SIZE entries and exposes the
// KERNAL_SIZE x KERNAL_SIZE window as one flattened bus, element (i,j) at
// bits [(i*K+j)*DATA_WIDTH +: DATA_WIDTH], (0,0) oldest.
// Ports:
//   clk, reset (sync, active-low), clear (sync frame restart)
//   in_valid/in_data : pixel stream
//   window_data, window_valid, out_row, out_col, frame_done : window output
module sliding_window_buffer
    import sliding_window_buffer_pkg::*;
#(
    parameter int DATA_WIDTH  = 32,
    parameter int IFM_SIZE    = 14,
    parameter int KERNAL_SIZE = 5,
    parameter int STRIDE      = 1
) (
    input  logic                                          clk,
    input  logic                                          reset,
    input  logic                                          clear,
    input  logic                                          in_valid,
    input  logic [DATA_WIDTH-1:0]                         in_data,
    output logic [KERNAL_SIZE*KERNAL_SIZE*DATA_WIDTH-1:0] window_data,
    output logic                                          window_valid,
    output logic [$clog2(IFM_SIZE)-1:0]                   out_row,
    output logic [$clog2(IFM_SIZE)-1:0]                   out_col,
    output logic                                          frame_done
);

    localparam int FIFO_SIZE     = fifo_size(IFM_SIZE, KERNAL_SIZE);
    localparam int IFM_SIZE_NEXT = ifm_size_next(IFM_SIZE, KERNAL_SIZE, STRIDE);
    localparam int COORD_BITS    = $clog2(IFM_SIZE);

    logic [DATA_WIDTH-1:0] entry_q [FIFO_SIZE];

    // A clear-cycle pixel is dropped, so the shift data stays as it was.
    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int n = 0; n < FIFO_SIZE; n++) begin
                entry_q[n] <= '0;
            end
        end else if (in_valid && !clear) begin
            entry_q[0] <= in_data;
            for (int n = 1; n < FIFO_SIZE; n++) begin
                entry_q[n] <= entry_q[n-1];
            end
        end
    end

    for (genvar i = 0; i < KERNAL_SIZE; i++) begin : g_win_row
        for (genvar j = 0; j < KERNAL_SIZE; j++) begin : g_win_col
            assign window_data[win_index(i, j, KERNAL_SIZE)*DATA_WIDTH +: DATA_WIDTH] =
                entry_q[(KERNAL_SIZE-1-i)*IFM_SIZE + (KERNAL_SIZE-1-j)];
        end
    end

    window_position_tracker #(
        .IFM_SIZE      (IFM_SIZE),
        .KERNAL_SIZE   (KERNAL_SIZE),
        .STRIDE        (STRIDE),
        .IFM_SIZE_NEXT (IFM_SIZE_NEXT),
        .COORD_BITS    (COORD_BITS)
    ) u_tracker (
        .clk          (clk),
        .reset        (reset),
        .clear        (clear),
        .in_valid     (in_valid),
        .window_valid (window_valid),
        .out_row      (out_row),
        .out_col      (out_col),
        .frame_done   (frame_done)
    );

endmodule

// File: tb/tb_sliding_window_buffer.sv
// Drives two buffers (STRIDE 1 and STRIDE 2, IFM 6, K 3) with the same
// stream; expected windows are queued at issue time and popped by a monitor.
module tb_sliding_window_buffer;

    localparam int IFM = 6;
    localparam int K   = 3;
    localparam int DW  = 32;
    localparam int WB  = K * K * DW;

    typedef struct packed {
        logic [WB-1:0] win;
        logic [2:0]    orow;
        logic [2:0]    ocol;
        logic          fd;
        int            cyc;
    } exp_t;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          clear = 1'b0;
    logic          in_valid = 1'b0;
    logic [DW-1:0] in_data = '0;

    logic [WB-1:0] wd  [2];
    logic          wv  [2];
    logic          fdo [2];
    logic [2:0]    orw [2];
    logic [2:0]    ocl [2];

    exp_t q0[$];
    exp_t q1[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    int   cyc = 0;
    int   wcnt [2];
    int   fcnt [2];
    logic prev_acc = 1'b0;

    sliding_window_buffer #(
        .DATA_WIDTH (DW), .IFM_SIZE (IFM), .KERNAL_SIZE (K), .STRIDE (1)
    ) dut_s1 (
        .clk (clk), .reset (reset), .clear (clear), .in_valid (in_valid),
        .in_data (in_data), .window_data (wd[0]), .window_valid (wv[0]),
        .out_row (orw[0]), .out_col (ocl[0]), .frame_done (fdo[0])
    );

    sliding_window_buffer #(
        .DATA_WIDTH (DW), .IFM_SIZE (IFM), .KERNAL_SIZE (K), .STRIDE (2)
    ) dut_s2 (
        .clk (clk), .reset (reset), .clear (clear), .in_valid (in_valid),
        .in_data (in_data), .window_data (wd[1]), .window_valid (wv[1]),
        .out_row (orw[1]), .out_col (ocl[1]), .frame_done (fdo[1])
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc      <= cyc + 1;
        prev_acc <= in_valid && !clear && reset;
    end

    task automatic check(input string nm, input longint act, input longint req);
        n_cmp++;
        if (act != req) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, req, $time);
        end
    endtask

    task automatic check_win(input string nm, input logic [WB-1:0] act,
                             input logic [WB-1:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", nm, act, req);
        end
    endtask

    // Monitor: every presented window must match the head of its queue.
    always @(negedge clk) begin
        for (int d = 0; d < 2; d++) begin
            exp_t e;
            bit   have;
            e    = '0;
            have = 1'b0;
            if (wv[d]) begin
                wcnt[d]++;
                if (fdo[d]) fcnt[d]++;
                check($sformatf("dut%0d valid_after_gap", d), prev_acc, 1);
                if (d == 0) begin
                    have = (q0.size() != 0);
                    if (have) e = q0.pop_front();
                end else begin
                    have = (q1.size() != 0);
                    if (have) e = q1.pop_front();
                end
                if (!have) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL dut%0d unexpected_window: got window, expected none", d);
                end else begin
                    check_win($sformatf("dut%0d window_data", d), wd[d], e.win);
                    check($sformatf("dut%0d out_row", d), orw[d], e.orow);
                    check($sformatf("dut%0d out_col", d), ocl[d], e.ocol);
                    check($sformatf("dut%0d frame_done", d), fdo[d], e.fd);
                    check($sformatf("dut%0d latency", d), cyc, e.cyc);
                end
            end else if (fdo[d]) begin
                check($sformatf("dut%0d frame_done_idle", d), fdo[d], wv[d]);
            end
        end
    end

    // Expected window for pixel (r,c) of a frame whose values are base+r*IFM+c+1.
    task automatic push_exp(input int base, input int r, input int c);
        for (int d = 0; d < 2; d++) begin
            int   s;
            int   n;
            exp_t e;
            s = d + 1;
            n = (IFM - K) / s + 1;
            e = '0;
            if (r >= K - 1 && c >= K - 1 && (r - (K - 1)) % s == 0 &&
                (c - (K - 1)) % s == 0) begin
                for (int i = 0; i < K; i++) begin
                    for (int j = 0; j < K; j++) begin
                        e.win[(i*K+j)*DW +: DW] =
                            DW'(base + (r - K + 1 + i) * IFM + (c - K + 1 + j) + 1);
                    end
                end
                e.orow = 3'((r - K + 1) / s);
                e.ocol = 3'((c - K + 1) / s);
                e.fd   = (int'(e.orow) == n - 1) && (int'(e.ocol) == n - 1);
                e.cyc  = cyc + 1;
                if (d == 0) q0.push_back(e);
                else q1.push_back(e);
            end
        end
    endtask

    task automatic send_pix(input int base, input int r, input int c);
        @(posedge clk);
        #1;
        clear    = 1'b0;
        in_valid = 1'b1;
        in_data  = DW'(base + r * IFM + c + 1);
        push_exp(base, r, c);
    endtask

    task automatic idle();
        @(posedge clk);
        #1;
        clear    = 1'b0;
        in_valid = 1'b0;
    endtask

    task automatic frame(input int base, input bit gap);
        for (int r = 0; r < IFM; r++) begin
            for (int c = 0; c < IFM; c++) begin
                send_pix(base, r, c);
                if (gap) idle();
            end
        end
    endtask

    task automatic zero_counts();
        for (int d = 0; d < 2; d++) begin
            wcnt[d] = 0;
            fcnt[d] = 0;
        end
    endtask

    task automatic drain_and_count(input string nm, input int w1, input int f1,
                                   input int w2, input int f2);
        idle();
        repeat (3) @(posedge clk);
        #1;
        check({nm, " queue0_left"}, q0.size(), 0);
        check({nm, " queue1_left"}, q1.size(), 0);
        check({nm, " windows_s1"}, wcnt[0], w1);
        check({nm, " frame_done_s1"}, fcnt[0], f1);
        check({nm, " windows_s2"}, wcnt[1], w2);
        check({nm, " frame_done_s2"}, fcnt[1], f2);
        q0.delete();
        q1.delete();
    endtask

    initial begin
        zero_counts();
        reset = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        for (int d = 0; d < 2; d++) begin
            check($sformatf("dut%0d reset window_valid", d), wv[d], 0);
            check($sformatf("dut%0d reset frame_done", d), fdo[d], 0);
            check($sformatf("dut%0d reset out_row", d), orw[d], 0);
            check($sformatf("dut%0d reset out_col", d), ocl[d], 0);
            check($sformatf("dut%0d reset window_data", d), wd[d][DW-1:0], 0);
        end
        reset = 1'b1;

        // Single frame, continuous stream.
        zero_counts();
        frame(0, 1'b0);
        drain_and_count("single", 16, 1, 4, 1);

        // Same frame with in_valid toggling.
        zero_counts();
        frame(0, 1'b1);
        drain_and_count("gapped", 16, 1, 4, 1);

        // Two frames back-to-back.
        zero_counts();
        frame(0, 1'b0);
        frame(100, 1'b0);
        drain_and_count("two_frames", 32, 2, 8, 2);

        // Reset after pixel 20, then a full frame from (0,0).
        zero_counts();
        for (int p = 0; p < 20; p++) send_pix(0, p / IFM, p % IFM);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        reset    = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b1;
        check("reset_mid window_valid", wv[0], 0);
        frame(0, 1'b0);
        drain_and_count("reset_mid", 4 + 16, 1, 2 + 4, 1);

        // Clear with in_valid on pixel 10 drops it and restarts at (0,0).
        zero_counts();
        for (int p = 0; p < 9; p++) send_pix(0, p / IFM, p % IFM);
        @(posedge clk);
        #1;
        in_valid = 1'b1;
        clear    = 1'b1;
        in_data  = DW'(10);
        frame(50, 1'b0);
        drain_and_count("clear", 16, 1, 4, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/sliding_window_buffer.md
Name: sliding_window_buffer

Overview:
- Parametrised line-buffer and window generator feeding the convolution units: takes a raster-order IFM pixel stream and presents a full KERNAL_SIZE x KERNAL_SIZE window as one flattened bus.
- Adds what the fixed 5x5 shift FIFO lacks: position tracking, a window-valid qualifier, stride, frame-done and frame restart.
- Sits between the IFM memory read path and the MAC array in each conv layer.

Parameters:
- DATA_WIDTH, 32, pixel width in bits.
- IFM_SIZE, 14, input feature map width and height (square).
- KERNAL_SIZE, 5, window edge; legal range 2..IFM_SIZE.
- STRIDE, 1, window step in both axes; legal range 1..KERNAL_SIZE.
- FIFO_SIZE, (KERNAL_SIZE-1)*IFM_SIZE+KERNAL_SIZE, derived shift depth (localparam).
- IFM_SIZE_NEXT, (IFM_SIZE-KERNAL_SIZE)/STRIDE+1, derived output edge (localparam).
- COORD_BITS, $clog2(IFM_SIZE), derived coordinate width (localparam).

Ports:
- clk  in  1  clock; all logic on the rising edge.
- reset  in  1  synchronous, active-low reset.
- clear  in  1  synchronous frame restart; zeroes counters only.
- in_valid  in  1  in_data is accepted on this edge.
- in_data  in  DATA_WIDTH  pixel in raster order (row-major, left to right).
- window_data  out  KERNAL_SIZE*KERNAL_SIZE*DATA_WIDTH  flattened window.
- window_valid  out  1  window_data is a complete, stride-aligned window.
- out_row  out  COORD_BITS  output-map row of the current window.
- out_col  out  COORD_BITS  output-map column of the current window.
- frame_done  out  1  pulses with the last window of a frame.

Behaviour:
- Reset (reset==0 at an edge): all shift entries = 0, in_row = in_col = 0, stride phases = 0, window_valid = frame_done = 0, out_row = out_col = 0.
  - Reset dominates clear and in_valid.
- Shift: on in_valid=1, entry[0] <= in_data and entry[n+1] <= entry[n]. With in_valid=0 every entry holds, so gaps are allowed.
- Window mapping is combinational from the shift entries.
  - Element (i,j), with i = window row top-to-bottom and j = column left-to-right, = entry[(K-1-i)*IFM_SIZE + (K-1-j)].
  - It occupies bits [(i*K+j)*DATA_WIDTH +: DATA_WIDTH].
  - Element (0,0) is the oldest pixel; element (K-1,K-1) is the newest.
- Input counters advance on in_valid:
  - in_col increments and wraps at IFM_SIZE-1 to 0, incrementing in_row.
  - in_row wraps at IFM_SIZE-1 to 0, which starts the next frame back-to-back with no idle cycle.
- Window qualification: on accepting pixel (r,c), window_valid <= 1 on the same edge iff all of:
  - r >= K-1 and c >= K-1;
  - (r-(K-1)) mod STRIDE == 0 and (c-(K-1)) mod STRIDE == 0.
  - Otherwise window_valid <= 0, including every edge with in_valid=0.
  - Latency: the window and its valid appear in the cycle after the accepting edge and stay coherent with window_data.
- Stride checks use per-axis phase counters, not modulo or divide logic.
  - col phase resets at every row start.
  - row phase resets at every frame start.
- out_row/out_col are registered with window_valid:
  - out_col counts emitted windows within the row, 0..IFM_SIZE_NEXT-1.
  - out_row counts window rows, 0..IFM_SIZE_NEXT-1, and returns to 0 after the last window.
  - Both hold when window_valid=0.
- frame_done <= 1 for one cycle, coinciding with the window_valid of the window at out_row = out_col = IFM_SIZE_NEXT-1.
- clear=1: counters and phases return to the reset state; window_valid and frame_done <= 0.
  - Shift data is untouched; stale data cannot qualify before K-1 new rows arrive.
  - clear and in_valid together: clear wins and the pixel is dropped.
- Reset mid-frame: the next accepted pixel is treated as (0,0) and no window from the aborted frame is emitted.
- Trailing pixels that do not complete a stride-aligned window (e.g. IFM_SIZE=6, K=3, STRIDE=2, pixel column 5) shift normally but never raise window_valid.

Decomposition:
- Shared conv package holds:
  - function win_index(i,j,K) = i*K+j;
  - the FIFO_SIZE and IFM_SIZE_NEXT formulas, which the conv controllers also reuse.
- One natural sub-module: window_position_tracker (input counters, stride phases, out_row/out_col, window_valid, frame_done).
- The shift array and flattening stay in the top level.

Test Plan:
- IFM_SIZE=6, K=3, STRIDE=1; pixel value = r*6+c+1, in_valid continuous:
  - first window_valid the cycle after pixel 15;
  - elements 0..8 = 1,2,3,7,8,9,13,14,15;
  - out_row=0, out_col=0;
  - exactly 16 windows; frame_done only with the window whose element 8 = 36.
- Same stimulus with STRIDE=2:
  - exactly 4 windows at pixel (r,c) = (2,2),(2,4),(4,2),(4,4);
  - element 0 values 1,3,13,15;
  - out coords (0,0),(0,1),(1,0),(1,1).
- STRIDE=1 with in_valid toggling 1/0: identical window sequence to scenario 1; window_valid never high in a cycle following in_valid=0.
- Two frames back-to-back, second frame values +100: 32 windows, two frame_done pulses, and the first window of frame 2 has element 0 = 101.
- reset low for one cycle after pixel 20, then a full frame:
  - no window until 15 new pixels;
  - 16 windows, out_row starting at 0.
- clear asserted together with in_valid at pixel 10: that pixel is dropped and the next pixel is counted as (0,0).
